// File: rtl/mimo_frame_sender.sv
// Frame buffer and sender feeding the MIMO detector input port.
// Loads H_WORDS channel words plus Y_WORDS data words, streams them out, then counts results.
module mimo_frame_sender #(
    parameter int DATA_W  = 128,
    parameter int H_WORDS = 4,
    parameter int Y_WORDS = 11
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_wr_valid,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    output logic              o_in_valid,
    output logic              o_flag,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_in_ready,
    input  logic              i_out_ready,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_err,
    output logic [1:0]        dbg_state
);

    localparam int FRAME_LEN = H_WORDS + Y_WORDS;
    localparam int PTR_W     = $clog2(FRAME_LEN);
    localparam int CNT_W     = $clog2(Y_WORDS + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_LEN - 1);
    localparam logic [PTR_W-1:0] H_LIMIT  = PTR_W'(H_WORDS);
    localparam logic [CNT_W-1:0] LAST_RES = CNT_W'(Y_WORDS - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state, state_n;

    logic [DATA_W-1:0] mem [FRAME_LEN];

    logic [PTR_W-1:0]  wr_ptr, wr_ptr_n;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_n;
    logic [PTR_W-1:0]  nxt_rd;
    logic [CNT_W-1:0]  res_cnt, res_cnt_n;
    logic              in_valid_n, flag_n, busy_n, done_n, err_n;
    logic [DATA_W-1:0] data_n;

    // Handshakes: a word moves on a rising edge where its valid and ready are both
    // high; valid never drops and data/flag never change while waiting for ready.
    assign o_wr_ready = (state == LOAD);
    assign dbg_state  = state;
    assign nxt_rd     = rd_ptr + PTR_W'(1);

    // Frame storage has no reset; contents are always rewritten before being read.
    always_ff @(posedge Clk) begin
        if (state == LOAD && i_wr_valid) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    always_comb begin
        state_n    = state;
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        res_cnt_n  = res_cnt;
        in_valid_n = o_in_valid;
        flag_n     = o_flag;
        data_n     = o_data;
        done_n     = 1'b0;
        err_n      = o_err;

        case (state)
            LOAD: begin
                if (i_out_ready) begin
                    err_n = 1'b1;
                end
                if (i_wr_valid) begin
                    if (wr_ptr == LAST_IDX) begin
                        wr_ptr_n   = '0;
                        rd_ptr_n   = '0;
                        res_cnt_n  = '0;
                        in_valid_n = 1'b1;
                        flag_n     = 1'b1;
                        data_n     = mem[0];
                        state_n    = SEND;
                    end else begin
                        wr_ptr_n = wr_ptr + PTR_W'(1);
                    end
                end
            end

            SEND: begin
                // Results may overlap sending because the detector is pipelined.
                if (i_out_ready) begin
                    if (res_cnt == LAST_RES) begin
                        err_n = 1'b1;
                    end else begin
                        res_cnt_n = res_cnt + CNT_W'(1);
                    end
                end
                if (o_in_valid && i_in_ready) begin
                    if (rd_ptr == LAST_IDX) begin
                        rd_ptr_n   = '0;
                        in_valid_n = 1'b0;
                        flag_n     = 1'b0;
                        data_n     = '0;
                        state_n    = WAIT;
                    end else begin
                        rd_ptr_n = nxt_rd;
                        data_n   = mem[nxt_rd];
                        flag_n   = (nxt_rd < H_LIMIT);
                    end
                end
            end

            WAIT: begin
                if (i_out_ready) begin
                    if (res_cnt == LAST_RES) begin
                        res_cnt_n = '0;
                        done_n    = 1'b1;
                        state_n   = LOAD;
                    end else begin
                        res_cnt_n = res_cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_n = LOAD;
            end
        endcase

        busy_n = (state_n != LOAD);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= LOAD;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            res_cnt      <= '0;
            o_in_valid   <= 1'b0;
            o_flag       <= 1'b0;
            o_data       <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            state        <= state_n;
            wr_ptr       <= wr_ptr_n;
            rd_ptr       <= rd_ptr_n;
            res_cnt      <= res_cnt_n;
            o_in_valid   <= in_valid_n;
            o_flag       <= flag_n;
            o_data       <= data_n;
            o_busy       <= busy_n;
            o_frame_done <= done_n;
            o_err        <= err_n;
        end
    end

endmodule
